// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver for the BLE command link: synchronizes RX, samples each bit at its
// centre and hands bytes to the command decoder through a rdy/clr_rdy handshake.
module uart_cmd_rx #(
    parameter int BAUD_DIV = 2604,
    parameter int HALF_DIV = BAUD_DIV / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       ovr_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [11:0] BAUD_RELOAD = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_RELOAD = 12'(HALF_DIV - 1);

    logic        rx_meta_r;
    logic        rx_sync_r;
    logic        rx_prev_r;
    state_t      state_r;
    state_t      state_nxt_s;
    logic [11:0] baud_cnt_r;
    logic [11:0] baud_cnt_nxt_s;
    logic [2:0]  bit_cnt_r;
    logic [2:0]  bit_cnt_nxt_s;
    logic [7:0]  shift_r;
    logic [7:0]  shift_nxt_s;
    logic        start_det_s;
    logic        baud_zero_s;
    logic        load_byte_s;
    logic        frame_bad_s;

    // Only a fresh high-to-low edge starts a frame, so a line held low never retriggers.
    assign start_det_s = rx_prev_r & ~rx_sync_r;
    assign baud_zero_s = (baud_cnt_r == 12'd0);

    // Two-flop synchronizer plus edge-history flop, preset to the idle-high level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= RX;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Next-state and datapath-update logic for the frame sequencer.
    always_comb begin
        state_nxt_s    = state_r;
        baud_cnt_nxt_s = baud_cnt_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        shift_nxt_s    = shift_r;
        load_byte_s    = 1'b0;
        frame_bad_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_det_s) begin
                    baud_cnt_nxt_s = HALF_RELOAD;
                    state_nxt_s    = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (!baud_zero_s) begin
                    baud_cnt_nxt_s = baud_cnt_r - 12'd1;
                end else if (rx_sync_r) begin
                    state_nxt_s = IDLE;
                end else begin
                    baud_cnt_nxt_s = BAUD_RELOAD;
                    bit_cnt_nxt_s  = 3'd0;
                    state_nxt_s    = DATA;
                end
            end
            DATA: begin
                if (baud_zero_s) begin
                    shift_nxt_s    = {rx_sync_r, shift_r[7:1]};
                    bit_cnt_nxt_s  = bit_cnt_r + 3'd1;
                    baud_cnt_nxt_s = BAUD_RELOAD;
                    if (bit_cnt_r == 3'd7) begin
                        state_nxt_s = STOP;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else begin
                    baud_cnt_nxt_s = baud_cnt_r - 12'd1;
                end
            end
            STOP: begin
                if (baud_zero_s) begin
                    if (rx_sync_r) begin
                        load_byte_s = 1'b1;
                    end else begin
                        frame_bad_s = 1'b1;
                    end
                    state_nxt_s = IDLE;
                end else begin
                    baud_cnt_nxt_s = baud_cnt_r - 12'd1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Sequencer state, counters and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            baud_cnt_r <= 12'd0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
        end else begin
            state_r    <= state_nxt_s;
            baud_cnt_r <= baud_cnt_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            shift_r    <= shift_nxt_s;
        end
    end

    // Registered outputs; a byte load takes priority over a simultaneous clr_rdy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data <= 8'h00;
            rdy     <= 1'b0;
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
            busy    <= 1'b0;
        end else begin
            frm_err <= frame_bad_s;
            ovr_err <= load_byte_s & rdy & ~clr_rdy;
            busy    <= (state_nxt_s != IDLE);
            if (load_byte_s) begin
                rx_data <= shift_r;
                rdy     <= 1'b1;
            end else if (clr_rdy) begin
                rx_data <= rx_data;
                rdy     <= 1'b0;
            end else begin
                rx_data <= rx_data;
                rdy     <= rdy;
            end
        end
    end

endmodule
